// File: rtl/dsa_step_sequencer.sv
// dsa_step_sequencer
// Host-side initiator for the DSA single-step debug interface. A host command
// (STEP_N / RELEASE / CLEAR_TRACE / NOP) arrives over a valid/ready port. The
// sequencer then drives step_enable, step_trigger and step_granularity toward
// the step controller. It counts the steps the controller completes and
// abandons a step that is not acknowledged within TIMEOUT_CYCLES. After each
// completed step it can record the interpolation FSM state in a trace buffer.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     host command handshake
//   cmd_op/count/gran       command opcode, step count, step granularity
//   step_enable/trigger     to step controller (trigger is a 1-cycle pulse)
//   step_granularity        to step controller, held until the next STEP_N
//   step_ack/step_ready     from step controller
//   fsm_state               target FSM state, captured on each completed step
//   busy/done/timeout       status: in progress / end pulse / sticky error
//   steps_done              steps completed in the current or last STEP_N
//   trace_rd_addr/data      combinational trace read port
//   trace_count/trace_ovf   valid trace entries / sticky dropped-capture flag
//
// Optional feature macro: DSA_STEP_TRACE_EN
//   When this macro is defined, the trace buffer is built.
//   When it is undefined, the trace outputs are tied to zero.
module dsa_step_sequencer #(
  parameter int CNT_W          = 16,
  parameter int TRACE_DEPTH    = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [CNT_W-1:0]             cmd_count,
  input  logic [1:0]                   cmd_gran,
  output logic                         step_enable,
  output logic                         step_trigger,
  output logic [1:0]                   step_granularity,
  input  logic                         step_ack,
  input  logic                         step_ready,
  input  logic [3:0]                   fsm_state,
  output logic                         busy,
  output logic                         done,
  output logic                         timeout,
  output logic [CNT_W-1:0]             steps_done,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_rd_addr,
  output logic [3:0]                   trace_rd_data,
  output logic [$clog2(TRACE_DEPTH):0] trace_count,
  output logic                         trace_ovf
);

  localparam int AW = $clog2(TRACE_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] OP_STEP_N      = 2'd0;
  localparam logic [1:0] OP_RELEASE     = 2'd1;
  localparam logic [1:0] OP_CLEAR_TRACE = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_TRIG,
    S_WAIT_ACK,
    S_WAIT_RDY,
    S_PAUSED
  } state_e;

  state_e           state_q;
  logic             step_enable_q;
  logic             step_trigger_q;
  logic             done_q;
  logic             timeout_q;
  logic [1:0]       gran_q;
  logic [CNT_W-1:0] steps_done_q;
  logic [CNT_W-1:0] remaining_q;
  logic [TW-1:0]    timer_q;

  logic cmd_accept;
  logic capture;
  logic timer_expired;

  // Commands are only taken while the target is idle or held paused.
  assign cmd_ready     = (state_q == S_IDLE) || (state_q == S_PAUSED);
  assign busy          = (state_q == S_ARM) || (state_q == S_TRIG) ||
                         (state_q == S_WAIT_ACK) || (state_q == S_WAIT_RDY);
  assign cmd_accept    = cmd_valid && cmd_ready;
  assign capture       = (state_q == S_WAIT_RDY) && step_ready;
  assign timer_expired = (timer_q == TIMER_LAST);

  assign step_enable      = step_enable_q;
  assign step_trigger     = step_trigger_q;
  assign step_granularity = gran_q;
  assign done             = done_q;
  assign timeout          = timeout_q;
  assign steps_done       = steps_done_q;

  // Main sequencer FSM. step_trigger_q is only raised on the edge that enters
  // S_TRIG, so it is a single-cycle pulse. The path back to S_TRIG passes
  // through S_WAIT_ACK and S_WAIT_RDY, which keeps the trigger low for at
  // least two cycles between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      step_enable_q  <= 1'b0;
      step_trigger_q <= 1'b0;
      done_q         <= 1'b0;
      timeout_q      <= 1'b0;
      gran_q         <= 2'd0;
      steps_done_q   <= '0;
      remaining_q    <= '0;
      timer_q        <= '0;
    end else begin
      done_q         <= 1'b0;
      step_trigger_q <= 1'b0;
      case (state_q)
        S_IDLE, S_PAUSED: begin
          if (cmd_accept) begin
            case (cmd_op)
              OP_STEP_N: begin
                gran_q       <= cmd_gran;
                remaining_q  <= cmd_count;
                steps_done_q <= '0;
                timeout_q    <= 1'b0;
                if (cmd_count == '0) begin
                  done_q <= 1'b1;
                end else if (state_q == S_PAUSED) begin
                  // The target is already paused, so ready is known to be high.
                  state_q        <= S_TRIG;
                  step_trigger_q <= 1'b1;
                end else begin
                  state_q       <= S_ARM;
                  step_enable_q <= 1'b1;
                end
              end
              OP_RELEASE: begin
                state_q       <= S_IDLE;
                step_enable_q <= 1'b0;
                done_q        <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        // No timeout here: the target may be idle, waiting to be started.
        S_ARM: begin
          if (step_ready) begin
            state_q        <= S_TRIG;
            step_trigger_q <= 1'b1;
          end
        end
        S_TRIG: begin
          state_q <= S_WAIT_ACK;
          timer_q <= '0;
        end
        // step_ready can still be high from the previous step here, so it is
        // ignored until the controller acknowledges the trigger.
        S_WAIT_ACK: begin
          if (step_ack) begin
            state_q <= S_WAIT_RDY;
            timer_q <= '0;
          end else if (timer_expired) begin
            state_q   <= S_PAUSED;
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_WAIT_RDY: begin
          if (step_ready) begin
            steps_done_q <= steps_done_q + CNT_W'(1);
            remaining_q  <= remaining_q - CNT_W'(1);
            if (remaining_q == CNT_W'(1)) begin
              state_q <= S_PAUSED;
              done_q  <= 1'b1;
            end else begin
              state_q        <= S_TRIG;
              step_trigger_q <= 1'b1;
            end
          end else if (timer_expired) begin
            state_q   <= S_PAUSED;
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef DSA_STEP_TRACE_EN
  localparam logic [AW:0] TRACE_FULL = (AW + 1)'(TRACE_DEPTH);

  logic [3:0]  trace_mem [TRACE_DEPTH];
  logic [AW:0] trace_count_q;
  logic        trace_ovf_q;
  logic        clear_trace;
  logic        trace_full;

  assign clear_trace = cmd_accept && (cmd_op == OP_CLEAR_TRACE);
  assign trace_full  = (trace_count_q == TRACE_FULL);

  // Fill level and overflow flag. When the buffer is full, the capture is
  // dropped but the step is still counted by the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trace_count_q <= '0;
      trace_ovf_q   <= 1'b0;
    end else if (clear_trace) begin
      trace_count_q <= '0;
      trace_ovf_q   <= 1'b0;
    end else if (capture) begin
      if (trace_full) begin
        trace_ovf_q <= 1'b1;
      end else begin
        trace_count_q <= trace_count_q + (AW + 1)'(1);
      end
    end
  end

  // Storage has no reset. Entries beyond trace_count are meaningless.
  always_ff @(posedge clk) begin
    if (capture && !trace_full) begin
      trace_mem[trace_count_q[AW-1:0]] <= fsm_state;
    end
  end

  assign trace_rd_data = trace_mem[trace_rd_addr];
  assign trace_count   = trace_count_q;
  assign trace_ovf     = trace_ovf_q;
`else
  logic unused_trace;

  assign unused_trace  = ^{fsm_state, trace_rd_addr, capture};
  assign trace_rd_data = 4'd0;
  assign trace_count   = '0;
  assign trace_ovf     = 1'b0;
`endif

endmodule

// File: tb/tb_dsa_step_sequencer.sv
// Self-checking bench for dsa_step_sequencer.
// A step-controller model reacts to step_trigger. It raises step_ack one cycle
// after the trigger and step_ready two cycles after that. With each completed
// step it advances fsm_state and pushes the new value onto the expected-trace
// queue. Every command that should end with a done pulse pushes its expected
// steps_done value onto a second queue, which is popped when done is seen.
module tb_dsa_step_sequencer;

  localparam logic [1:0] OP_STEP_N      = 2'd0;
  localparam logic [1:0] OP_RELEASE     = 2'd1;
  localparam logic [1:0] OP_CLEAR_TRACE = 2'd2;
  localparam logic [1:0] OP_NOP         = 2'd3;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_count;
  logic [1:0]  cmd_gran;
  logic        step_enable;
  logic        step_trigger;
  logic [1:0]  step_granularity;
  logic        step_ack;
  logic        step_ready;
  logic [3:0]  fsm_state;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [15:0] steps_done;
  logic [3:0]  trace_rd_addr;
  logic [3:0]  trace_rd_data;
  logic [4:0]  trace_count;
  logic        trace_ovf;

  int checks = 0;
  int errors = 0;

  logic [3:0]  expTrace[$];
  logic [15:0] expSteps[$];

  int   trigCount = 0;
  int   doneCount = 0;
  int   lowRun = 100;
  time  lastTrigTime = 0;
  int   modelTrig = 0;
  int   ackLimit = 1000;
  int   phase = 0;
  logic [3:0] modelState = 4'd0;

  dsa_step_sequencer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_op           (cmd_op),
    .cmd_count        (cmd_count),
    .cmd_gran         (cmd_gran),
    .step_enable      (step_enable),
    .step_trigger     (step_trigger),
    .step_granularity (step_granularity),
    .step_ack         (step_ack),
    .step_ready       (step_ready),
    .fsm_state        (fsm_state),
    .busy             (busy),
    .done             (done),
    .timeout          (timeout),
    .steps_done       (steps_done),
    .trace_rd_addr    (trace_rd_addr),
    .trace_rd_data    (trace_rd_data),
    .trace_count      (trace_count),
    .trace_ovf        (trace_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global watchdog
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Step controller model, driven on the falling edge
  initial begin
    step_ack   = 1'b0;
    step_ready = 1'b1;
    fsm_state  = 4'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        step_ack   = 1'b0;
        step_ready = 1'b1;
        phase      = 0;
      end else if (step_trigger) begin
        step_ready = 1'b0;
        step_ack   = 1'b0;
        modelTrig++;
        phase = (modelTrig <= ackLimit) ? 1 : 9;
      end else begin
        case (phase)
          1: begin step_ack = 1'b1; phase = 2; end
          2: begin step_ack = 1'b0; phase = 3; end
          3: begin
            modelState = modelState + 4'd1;
            fsm_state  = modelState;
            step_ready = 1'b1;
            expTrace.push_back(modelState);
            phase = 0;
          end
          default: ;
        endcase
      end
    end
  end

  // Monitor: counts trigger and done pulses and checks trigger spacing
  initial begin
    forever begin
      @(negedge clk);
      if (step_trigger) begin
        checkOutput("trig_gap_ge2", 32'(lowRun >= 2), 32'd1);
        trigCount++;
        lastTrigTime = $time;
        lowRun = 0;
      end else begin
        lowRun++;
      end
      if (done) doneCount++;
    end
  end

  task automatic applyStimulus(input logic [1:0] op, input logic [15:0] count, input logic [1:0] gran,
                               input bit expectDone, input logic [15:0] expDoneSteps);
    int guard = 0;
    while (!cmd_ready && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) checkOutput("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = count;
    cmd_gran  = gran;
    if (expectDone) expSteps.push_back(expDoneSteps);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
  endtask

  task automatic waitDone(input string tag, input int maxCycles, output int waited);
    waited = 0;
    while (done !== 1'b1 && waited < maxCycles) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
    if (expSteps.size() > 0) checkOutput({tag, "_steps"}, 32'(steps_done), 32'(expSteps.pop_front()));
    else checkOutput({tag, "_sb_empty"}, 32'd0, 32'd1);
  endtask

  task automatic clearCounts();
    trigCount = 0;
    doneCount = 0;
    modelTrig = 0;
  endtask

  initial begin
    int w;
    int guard;
    int dt;
    rst_n         = 1'b0;
    cmd_valid     = 1'b0;
    cmd_op        = OP_NOP;
    cmd_count     = 16'd0;
    cmd_gran      = 2'd0;
    trace_rd_addr = 4'd0;
    repeat (3) @(negedge clk);

    // Reset values
    checkOutput("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("rst_step_enable", {31'd0, step_enable}, 32'd0);
    checkOutput("rst_trigger", {31'd0, step_trigger}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_timeout", {31'd0, timeout}, 32'd0);
    checkOutput("rst_steps_done", 32'(steps_done), 32'd0);
    checkOutput("rst_trace_count", 32'(trace_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // STEP_N count=3 from idle
    $display("[TB] STEP_N 3");
    clearCounts();
    applyStimulus(OP_STEP_N, 16'd3, 2'd0, 1'b1, 16'd3);
    checkOutput("s3_busy", {31'd0, busy}, 32'd1);
    waitDone("s3", 200, w);
    repeat (3) @(negedge clk);
    checkOutput("s3_trig_count", 32'(trigCount), 32'd3);
    checkOutput("s3_done_count", 32'(doneCount), 32'd1);
    checkOutput("s3_enable", {31'd0, step_enable}, 32'd1);
    checkOutput("s3_paused_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("s3_busy_after", {31'd0, busy}, 32'd0);
    checkOutput("s3_gran", 32'(step_granularity), 32'd0);
`ifdef DSA_STEP_TRACE_EN
    checkOutput("s3_trace_count", 32'(trace_count), 32'd3);
    for (int i = 0; i < 3; i++) begin
      trace_rd_addr = 4'(i);
      #1;
      checkOutput("s3_trace_data", 32'(trace_rd_data), 32'(expTrace.pop_front()));
    end
`else
    checkOutput("s3_trace_count", 32'(trace_count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      trace_rd_addr = 4'(i);
      #1;
      checkOutput("s3_trace_data_off", 32'(trace_rd_data), 32'd0);
    end
    expTrace.delete();
`endif
    @(negedge clk);

    // RELEASE from paused: enable drops and done pulses the next cycle
    $display("[TB] RELEASE");
    applyStimulus(OP_RELEASE, 16'd0, 2'd0, 1'b1, 16'd3);
    checkOutput("rel_enable", {31'd0, step_enable}, 32'd0);
    checkOutput("rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    waitDone("rel", 0, w);
    @(negedge clk);
    checkOutput("rel_done_single", {31'd0, done}, 32'd0);

    // STEP_N count=0 from idle: no trigger, immediate done
    $display("[TB] STEP_N 0");
    clearCounts();
    applyStimulus(OP_STEP_N, 16'd0, 2'd1, 1'b1, 16'd0);
    waitDone("s0", 0, w);
    checkOutput("s0_enable", {31'd0, step_enable}, 32'd0);
    checkOutput("s0_idle", {31'd0, cmd_ready}, 32'd1);
    repeat (4) @(negedge clk);
    checkOutput("s0_trig_count", 32'(trigCount), 32'd0);

    // RELEASE in idle still pulses done
    applyStimulus(OP_RELEASE, 16'd0, 2'd0, 1'b1, 16'd0);
    waitDone("rel_idle", 0, w);

    // A command held while busy is not taken until the first one finishes
    $display("[TB] held command");
    clearCounts();
    applyStimulus(OP_STEP_N, 16'd2, 2'd2, 1'b1, 16'd2);
    cmd_valid = 1'b1;
    cmd_op    = OP_STEP_N;
    cmd_count = 16'd1;
    cmd_gran  = 2'd1;
    expSteps.push_back(16'd1);
    waitDone("hold_first", 200, w);
    checkOutput("hold_first_gran", 32'(step_granularity), 32'd2);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    waitDone("hold_second", 200, w);
    checkOutput("hold_second_gran", 32'(step_granularity), 32'd1);
    repeat (2) @(negedge clk);
    checkOutput("hold_trig_count", 32'(trigCount), 32'd3);

    // Timeout: the 2nd trigger is never acknowledged
    $display("[TB] timeout");
    clearCounts();
    ackLimit = 1;
    applyStimulus(OP_STEP_N, 16'd5, 2'd0, 1'b1, 16'd1);
    waitDone("to", 2000, w);
    dt = int'(($time - lastTrigTime) / 10);
    checkOutput("to_latency_window", 32'((dt >= 1024) && (dt <= 1026)), 32'd1);
    checkOutput("to_flag", {31'd0, timeout}, 32'd1);
    checkOutput("to_enable", {31'd0, step_enable}, 32'd1);
    checkOutput("to_trig_count", 32'(trigCount), 32'd2);
    repeat (3) @(negedge clk);
    checkOutput("to_sticky", {31'd0, timeout}, 32'd1);
    clearCounts();
    ackLimit = 1000;
    applyStimulus(OP_STEP_N, 16'd1, 2'd0, 1'b1, 16'd1);
    checkOutput("to_cleared", {31'd0, timeout}, 32'd0);
    waitDone("to_recover", 200, w);

    // 20 steps overflow the 16-entry trace
    $display("[TB] trace overflow");
    applyStimulus(OP_CLEAR_TRACE, 16'd0, 2'd0, 1'b0, 16'd0);
    expTrace.delete();
    checkOutput("clr_no_done", {31'd0, done}, 32'd0);
    checkOutput("clr_enable_kept", {31'd0, step_enable}, 32'd1);
    checkOutput("clr_count", 32'(trace_count), 32'd0);
    applyStimulus(OP_STEP_N, 16'd20, 2'd0, 1'b1, 16'd20);
    waitDone("s20", 500, w);
    @(negedge clk);
`ifdef DSA_STEP_TRACE_EN
    checkOutput("s20_trace_count", 32'(trace_count), 32'd16);
    checkOutput("s20_trace_ovf", {31'd0, trace_ovf}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      trace_rd_addr = 4'(i);
      #1;
      checkOutput("s20_trace_data", 32'(trace_rd_data), 32'(expTrace.pop_front()));
    end
`else
    checkOutput("s20_trace_count", 32'(trace_count), 32'd0);
    checkOutput("s20_trace_ovf", {31'd0, trace_ovf}, 32'd0);
`endif
    expTrace.delete();
    @(negedge clk);
    applyStimulus(OP_CLEAR_TRACE, 16'd0, 2'd0, 1'b0, 16'd0);
    checkOutput("s20_clr_count", 32'(trace_count), 32'd0);
    checkOutput("s20_clr_ovf", {31'd0, trace_ovf}, 32'd0);
    checkOutput("s20_clr_state", {31'd0, cmd_ready}, 32'd1);

    // Reset during S_WAIT_RDY of the second step
    $display("[TB] reset mid-command");
    applyStimulus(OP_RELEASE, 16'd0, 2'd0, 1'b1, 16'd20);
    waitDone("rel2", 0, w);
    clearCounts();
    applyStimulus(OP_STEP_N, 16'd3, 2'd1, 1'b1, 16'd3);
    guard = 0;
    do begin
      @(negedge clk);
      #1;
      guard++;
    end while (!(modelTrig == 2 && step_ack) && guard < 200);
    checkOutput("mid_ack_seen", {31'd0, step_ack}, 32'd1);
    @(negedge clk);
    checkOutput("mid_pre_steps", 32'(steps_done), 32'd1);
    checkOutput("mid_pre_busy", {31'd0, busy}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_enable", {31'd0, step_enable}, 32'd0);
    checkOutput("mid_busy", {31'd0, busy}, 32'd0);
    checkOutput("mid_steps", 32'(steps_done), 32'd0);
    checkOutput("mid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("mid_trace_count", 32'(trace_count), 32'd0);
`ifndef DSA_STEP_TRACE_EN
    for (int i = 0; i < 16; i++) begin
      trace_rd_addr = 4'(i);
      #1;
      checkOutput("mid_trace_data_off", 32'(trace_rd_data), 32'd0);
    end
`endif
    expSteps.delete();
    expTrace.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsa_step_sequencer.md
Name: dsa_step_sequencer

Overview:
Host-side initiator for the DSA single-step debug interface. Accepts host commands over a valid/ready port (e.g. "step N times at granularity G") and drives step_enable, step_granularity and step_trigger toward the step controller. It consumes step_ack/step_ready back from the controller, counts completed steps and applies a timeout. It also records the interpolation FSM state after each completed step into a small trace buffer that the JTAG host can read.

Parameters:
CNT_W, 16, width of step count and steps_done
TRACE_DEPTH, 16, trace buffer entries (power of 2)
TIMEOUT_CYCLES, 1024, max cycles waiting for step_ack or step_ready after a trigger

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
cmd_valid  in  1  host command valid
cmd_ready  out  1  sequencer can accept a command
cmd_op  in  2  0=STEP_N, 1=RELEASE, 2=CLEAR_TRACE, 3=NOP
cmd_count  in  CNT_W  number of steps for STEP_N
cmd_gran  in  2  granularity for STEP_N (0 state, 1 pixel, 2 group)
step_enable  out  1  to step controller
step_trigger  out  1  to step controller, single-cycle pulse
step_granularity  out  2  to step controller
step_ack  in  1  from step controller
step_ready  in  1  from step controller (target paused)
fsm_state  in  4  active FSM state (seq or simd already muxed)
busy  out  1  command in progress
done  out  1  one-cycle pulse at end of STEP_N or RELEASE
timeout  out  1  sticky error flag, cleared by next accepted STEP_N
steps_done  out  CNT_W  steps completed in the current or last STEP_N
trace_rd_addr  in  $clog2(TRACE_DEPTH)  trace read index
trace_rd_data  out  4  FSM state recorded at trace_rd_addr, combinational read
trace_count  out  $clog2(TRACE_DEPTH)+1  valid entries
trace_ovf  out  1  sticky: a capture was dropped because the buffer was full

Behaviour:
- Reset: all outputs 0, except cmd_ready=1. State S_IDLE. Trace contents are don't-care; trace_count=0.
- States:
  - S_IDLE: step_enable=0.
  - S_ARM: step_enable=1. Wait for step_ready=1. No timeout, because the target may legitimately be idle waiting for start.
  - S_TRIG: step_trigger=1 for exactly one cycle, then S_WAIT_ACK.
  - S_WAIT_ACK: wait for step_ack=1, then S_WAIT_RDY.
  - S_WAIT_RDY: wait for step_ready=1. On that cycle, capture fsm_state into the trace, steps_done+=1, remaining-=1. If remaining==0, go to S_PAUSED with a done pulse; else go to S_TRIG.
  - S_PAUSED: step_enable=1, target held, done idle.
- cmd_ready=1 only in S_IDLE and S_PAUSED. A command is accepted on cmd_valid&&cmd_ready.
- STEP_N:
  - Latch step_granularity=cmd_gran, remaining=cmd_count; clear steps_done and timeout.
  - From S_IDLE go to S_ARM. From S_PAUSED go directly to S_TRIG, since ready is already high.
  - cmd_count==0: no trigger is issued; done pulses the next cycle. Go to S_PAUSED from S_PAUSED, or stay in S_IDLE from S_IDLE.
- RELEASE: step_enable drops the next cycle, then S_IDLE, with a done pulse one cycle after acceptance. In S_IDLE, RELEASE is a no-op but still pulses done.
- CLEAR_TRACE: trace_count=0 and trace_ovf=0 in one cycle; state unchanged; no done pulse. NOP: no effect.
- step_granularity holds its latched value until the next STEP_N.
- Trigger spacing: step_trigger is low for at least 2 cycles between pulses (S_WAIT_ACK plus S_WAIT_RDY minimum), so the controller's edge detector always sees a fresh rising edge.
- step_ready may still be high in the cycle after the trigger pulse. It is ignored until step_ack has been seen.
- Timeout:
  - A counter resets on entry to S_WAIT_ACK and S_WAIT_RDY.
  - Reaching TIMEOUT_CYCLES sets timeout=1, abandons the command (step_enable stays 1), goes to S_PAUSED and pulses done.
  - steps_done keeps its partial value.
- Trace full (trace_count==TRACE_DEPTH): the capture is dropped and trace_ovf=1. The step still counts.
- busy=1 in S_ARM, S_TRIG, S_WAIT_ACK and S_WAIT_RDY.
- rst_n asserted mid-command: immediate return to reset values. step_enable drops asynchronously, so the target runs free.

Optional Feature:
DSA_STEP_TRACE_EN.
- Defined: trace buffer as described above.
- Undefined: no storage is instantiated; trace_rd_data=0, trace_count=0, trace_ovf=0. Everything else is unchanged.

Test Plan:
- Reset, then STEP_N count=3 gran=0 with a controller model giving ack 1 cycle after trigger and ready 2 cycles later -> exactly 3 trigger pulses, steps_done=3, one done pulse, state S_PAUSED, step_enable=1, trace_count=3 with the model states in order.
- STEP_N count=0 from S_IDLE -> no trigger, step_enable stays 0, done pulses 1 cycle after acceptance.
- STEP_N count=5 with the model never asserting ack after the 2nd trigger -> timeout=1 after 1024 cycles, steps_done=1, done pulse, step_enable=1.
- 20 steps with TRACE_DEPTH=16 -> trace_count=16, trace_ovf=1, steps_done=20; CLEAR_TRACE -> trace_count=0, trace_ovf=0.
- From S_PAUSED issue RELEASE -> step_enable=0 next cycle, done pulse, cmd_ready=1; cmd_valid with STEP_N while busy -> not accepted until S_PAUSED.
- Drop rst_n during S_WAIT_RDY -> step_enable=0, busy=0, steps_done=0 immediately; with DSA_STEP_TRACE_EN undefined, trace_rd_data=0 for all addresses.
